// File: rtl/pulse_burst_scheduler_if.sv
// Request/grant/pulse bundle between requesters and the shared pulse-burst scheduler.
// The master modport belongs to the requester side and the slave modport to the scheduler.
interface pulse_burst_scheduler_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned INT_W   = 8,
  parameter int unsigned ID_W    = 2
);
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*CNT_W-1:0] req_len;
  logic [INT_W-1:0]         interval;
  logic [NUM_REQ-1:0]       grant;
  logic [ID_W-1:0]          grant_id;
  logic                     busy;
  logic                     pulse_out;
  logic                     done;
  logic [ID_W-1:0]          done_id;

  modport master (
    output req, req_len, interval,
    input  grant, grant_id, busy, pulse_out, done, done_id
  );

  modport slave (
    input  req, req_len, interval,
    output grant, grant_id, busy, pulse_out, done, done_id
  );
endinterface

// File: rtl/pulse_burst_scheduler.sv
// Round-robin scheduler that shares one pulse-train timer between NUM_REQ requesters.
// The granted requester gets a burst of single-cycle pulses, followed by a one-cycle done strobe.
module pulse_burst_scheduler #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned INT_W   = 8,
  parameter int unsigned ID_W    = 2
) (
  input logic                     clk,
  input logic                     rst_n,
  pulse_burst_scheduler_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e             state_q, state_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [CNT_W-1:0]   len_q, len_d;
  logic [INT_W-1:0]   int_q, int_d;
  logic [INT_W-1:0]   icnt_q, icnt_d;
  logic [CNT_W-1:0]   pcnt_q, pcnt_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [ID_W-1:0]    grant_id_q, grant_id_d;
  logic               busy_q, busy_d;
  logic               pulse_q, pulse_d;
  logic               done_q, done_d;
  logic [ID_W-1:0]    done_id_q, done_id_d;

  logic [2*NUM_REQ-1:0] req_dbl;
  logic [NUM_REQ-1:0]   req_rot;
  logic                 arb_found;
  int unsigned          arb_off;
  logic [ID_W-1:0]      arb_id;
  logic [CNT_W-1:0]     arb_len;
  logic [INT_W-1:0]     eff_int;
  logic [ID_W-1:0]      ptr_next;

  // Rotate requests so bit 0 is the pointer position; the first set bit wins.
  always_comb begin
    req_dbl   = {bus.req, bus.req} >> ptr_q;
    req_rot   = req_dbl[NUM_REQ-1:0];
    arb_found = 1'b0;
    arb_off   = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!arb_found && req_rot[i]) begin
        arb_found = 1'b1;
        arb_off   = i;
      end
    end
    arb_id = ID_W'((int'(ptr_q) + arb_off) % NUM_REQ);
  end

  always_comb begin
    arb_len = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (ID_W'(i) == arb_id) begin
        arb_len = bus.req_len[i*CNT_W +: CNT_W];
      end
    end
  end

  // Interval 0 and 1 both mean a pulse every cycle.
  assign eff_int  = (bus.interval <= INT_W'(1)) ? INT_W'(1) : bus.interval;
  assign ptr_next = (grant_id_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_id_q + ID_W'(1);

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    len_d      = len_q;
    int_d      = int_q;
    icnt_d     = icnt_q;
    pcnt_d     = pcnt_q;
    grant_d    = grant_q;
    grant_id_d = grant_id_q;
    busy_d     = busy_q;
    pulse_d    = 1'b0;
    done_d     = 1'b0;
    done_id_d  = done_id_q;

    unique case (state_q)
      StIdle: begin
        if (arb_found) begin
          state_d    = StRun;
          grant_d    = NUM_REQ'(1) << arb_id;
          grant_id_d = arb_id;
          busy_d     = 1'b1;
          len_d      = arb_len;
          int_d      = eff_int;
          icnt_d     = '0;
          pcnt_d     = '0;
        end
      end
      StRun: begin
        // Checking the pulse count first keeps a zero-length burst pulse-free.
        if (pcnt_q == len_q) begin
          state_d   = StDone;
          grant_d   = '0;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          done_id_d = grant_id_q;
          ptr_d     = ptr_next;
        end else if (icnt_q == int_q - INT_W'(1)) begin
          icnt_d  = '0;
          pulse_d = 1'b1;
          pcnt_d  = pcnt_q + CNT_W'(1);
        end else begin
          icnt_d = icnt_q + INT_W'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      ptr_q      <= '0;
      len_q      <= '0;
      int_q      <= '0;
      icnt_q     <= '0;
      pcnt_q     <= '0;
      grant_q    <= '0;
      grant_id_q <= '0;
      busy_q     <= 1'b0;
      pulse_q    <= 1'b0;
      done_q     <= 1'b0;
      done_id_q  <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      len_q      <= len_d;
      int_q      <= int_d;
      icnt_q     <= icnt_d;
      pcnt_q     <= pcnt_d;
      grant_q    <= grant_d;
      grant_id_q <= grant_id_d;
      busy_q     <= busy_d;
      pulse_q    <= pulse_d;
      done_q     <= done_d;
      done_id_q  <= done_id_d;
    end
  end

  assign bus.grant     = grant_q;
  assign bus.grant_id  = grant_id_q;
  assign bus.busy      = busy_q;
  assign bus.pulse_out = pulse_q;
  assign bus.done      = done_q;
  assign bus.done_id   = done_id_q;

  grant_onehot_a: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(grant_q));
  pulse_in_run_a: assert property (@(posedge clk) disable iff (!rst_n)
                                   pulse_q |-> (state_q == StRun));
  busy_grant_a:   assert property (@(posedge clk) disable iff (!rst_n)
                                   busy_q == (grant_q != '0));

endmodule

// File: tb/tb_pulse_burst_scheduler.sv
// Directed bench for pulse_burst_scheduler: reset, single burst, round-robin, boundaries,
// mid-burst request drop, bus change during a burst and reset during a burst.
module tb_pulse_burst_scheduler;
  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned INT_W   = 8;
  localparam int unsigned ID_W    = 2;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  pulse_burst_scheduler_if #(
    .NUM_REQ(NUM_REQ), .CNT_W(CNT_W), .INT_W(INT_W), .ID_W(ID_W)
  ) bus ();

  pulse_burst_scheduler #(
    .NUM_REQ(NUM_REQ), .CNT_W(CNT_W), .INT_W(INT_W), .ID_W(ID_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk(tag, 32'({bus.grant, bus.grant_id, bus.busy, bus.pulse_out, bus.done, bus.done_id}), 32'd0);
  endtask

  // act 1: drop all requests; act 3: drop requests and change interval/req_len[2]
  task automatic do_act(input int act);
    if (act == 1) begin
      bus.req = '0;
    end else if (act == 3) begin
      bus.req              = '0;
      bus.interval         = 8'd4;
      bus.req_len[16 +: 8] = 8'd2;
    end
  endtask

  // Requests must already be driven; the first edge here is the arbitration edge E0.
  task automatic burst(input int id, input int len, input int eint, input int act_t,
                       input int act);
    step();
    chk("grant", 32'(bus.grant), 32'(1) << id);
    chk("grant_id", 32'(bus.grant_id), 32'(id));
    chk("busy", 32'(bus.busy), 32'd1);
    chk("pulse_at_e0", 32'(bus.pulse_out), 32'd0);
    if (act_t == 0) do_act(act);
    for (int t = 1; t <= len * eint; t++) begin
      step();
      chk("pulse", 32'(bus.pulse_out), 32'((t % eint) == 0));
      chk("grant_hold", 32'({bus.grant, bus.busy, bus.done}), (32'(1) << (id + 2)) | 32'd2);
      if (t == act_t) do_act(act);
    end
    step();
    chk("done", 32'(bus.done), 32'd1);
    chk("done_id", 32'(bus.done_id), 32'(id));
    chk("done_quiet", 32'({bus.grant, bus.busy, bus.pulse_out}), 32'd0);
    step();
    chk("idle_after_done", 32'({bus.grant, bus.busy, bus.pulse_out, bus.done}), 32'd0);
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.req      = '0;
    bus.req_len  = '0;
    bus.interval = '0;

    // Reset and idle
    repeat (10) step();
    chk_zero("reset");
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      chk_zero("idle");
    end

    // Single burst: requester 0, length 4, interval 3
    bus.interval        = 8'd3;
    bus.req_len[0 +: 8] = 8'd4;
    bus.req             = 4'b0001;
    burst(0, 4, 3, 0, 1);

    // Round-robin from a fresh pointer
    rst_n = 1'b0;
    repeat (2) step();
    rst_n        = 1'b1;
    bus.req_len  = {8'd2, 8'd2, 8'd2, 8'd2};
    bus.interval = 8'd2;
    bus.req      = 4'b1111;
    burst(0, 2, 2, -1, 0);
    burst(1, 2, 2, -1, 0);
    burst(2, 2, 2, -1, 0);
    burst(3, 2, 2, -1, 0);
    burst(0, 2, 2, 0, 1);

    // interval 0 acts as 1: five back-to-back pulses
    bus.interval         = 8'd0;
    bus.req_len[8 +: 8]  = 8'd5;
    bus.req              = 4'b0010;
    burst(1, 5, 1, 0, 1);

    // Zero-length burst: done one cycle after grant
    bus.req_len[16 +: 8] = 8'd0;
    bus.req              = 4'b0100;
    burst(2, 0, 1, 0, 1);

    // Maximum length, no counter wrap
    bus.interval         = 8'd1;
    bus.req_len[24 +: 8] = 8'd255;
    bus.req              = 4'b1000;
    burst(3, 255, 1, 0, 1);

    // Request dropped after the first pulse
    bus.interval        = 8'd2;
    bus.req_len[8 +: 8] = 8'd3;
    bus.req             = 4'b0010;
    burst(1, 3, 2, 2, 1);

    // Bus change mid-burst affects only the next burst
    bus.req_len[16 +: 8] = 8'd3;
    bus.req              = 4'b0100;
    burst(2, 3, 2, 1, 3);
    bus.req = 4'b0100;
    burst(2, 2, 4, 0, 1);

    // Reset during the second pulse interval of a burst for requester 1
    bus.req_len[8 +: 8] = 8'd3;
    bus.req             = 4'b0110;
    step();
    chk("pre_reset_grant_id", 32'(bus.grant_id), 32'd1);
    for (int t = 1; t <= 5; t++) begin
      step();
      chk("pre_reset_pulse", 32'(bus.pulse_out), 32'(t == 4));
    end
    rst_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk_zero("mid_burst_reset");
    end
    rst_n   = 1'b1;
    bus.req = 4'b0111;
    burst(0, 2, 4, 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pulse_burst_scheduler.md
Name: pulse_burst_scheduler

Overview:
- Shares one pulse-train timer between NUM_REQ requesters.
- Arbitrates requests round-robin and grants one requester at a time.
- Emits a burst of single-cycle pulses for the granted requester: per-requester burst length, shared programmable interval.
- Reports completion with a one-cycle done strobe and the completed requester index.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- CNT_W, 8, width of each burst-length field and of the pulse counter.
- INT_W, 8, width of the interval input and of the interval counter.
- ID_W, 2, width of grant_id/done_id; must satisfy 2**ID_W >= NUM_REQ.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- req  in  NUM_REQ  level request per requester; bit i = requester i.
- req_len  in  NUM_REQ*CNT_W  flat burst lengths; requester i uses bits [i*CNT_W +: CNT_W].
- interval  in  INT_W  pulse spacing in clocks, shared by all requesters.
- grant  out  NUM_REQ  one-hot; held for the whole active burst.
- grant_id  out  ID_W  index of the granted requester; valid while busy=1.
- busy  out  1  high while in RUN.
- pulse_out  out  1  one-cycle pulse train for the granted requester.
- done  out  1  one-cycle strobe at end of each burst.
- done_id  out  ID_W  index of the requester whose burst just finished; valid when done=1.

Behaviour:
- Reset: when rst_n=0 at a rising edge, all outputs, counters and the state are cleared to 0 and the state goes to IDLE. The round-robin pointer resets to 0, so requester 0 has top priority. Reset mid-burst aborts the burst immediately with no done strobe.
- States: IDLE, RUN, DONE. All outputs are registered.
- IDLE:
  - At each edge, if any req bit is set, select the first set bit searching upward (with wrap) from the pointer.
  - At that edge: set grant/grant_id and busy=1, latch that requester's req_len into len_r, latch the effective interval into int_r, clear both counters, go to RUN.
  - Latency: req sampled high at edge E0 gives grant high from E0.
- Effective interval: int_r = 1 if interval is 0 or 1, else interval. interval=0 or 1 produces a pulse every cycle.
- len_r = 0: RUN lasts exactly one cycle with no pulses, then DONE.
- RUN:
  - Interval counter counts 0..int_r-1 and wraps.
  - pulse_out is set at the edge where the counter wraps. With grant at E0, pulse k (k = 1..len_r) is high for one cycle starting at edge E0 + k*int_r.
  - Pulse counter increments on each pulse. After pulse len_r is issued, the next edge goes to DONE.
- DONE (one cycle):
  - grant=0, busy=0, pulse_out=0, done=1, done_id=granted index.
  - Pointer = granted index + 1, modulo NUM_REQ.
  - Next edge goes to IDLE; next grant no earlier than E0 + len_r*int_r + 2.
- req, req_len and interval are ignored outside IDLE arbitration. Deasserting req mid-burst does not shorten the burst. A requester holding req high after its done is re-granted only after the other pending requesters, per round-robin.
- Pulse counter is CNT_W wide and never wraps: maximum burst is 2**CNT_W - 1 pulses.
- Simultaneous requests resolve strictly by pointer order; there is no starvation, since each requester waits at most NUM_REQ-1 bursts.
- pulse_out never asserts outside RUN; grant is never multi-hot.

Test Plan:
- Reset/idle: rst_n=0 for 10 cycles, req=0 -> all outputs 0. Release reset, req stays 0 for 20 cycles -> outputs stay 0.
- Single burst: interval=3, req[0]=1 with len 4 -> grant=0001 from E0; pulse_out high at E0+3, +6, +9, +12; done=1 with done_id=0 at E0+13; grant=0 at E0+13.
- Round-robin: req=1111 held, all lengths 2, interval=2 -> grant_id sequence 0,1,2,3,0 with one DONE cycle between bursts. Each burst has exactly 2 pulses spaced 2 cycles.
- Boundaries:
  - interval=0, len 5 -> 5 consecutive pulse cycles.
  - len 0 -> no pulse; done at E0+1.
  - len 255, interval=1 -> 255 pulses and no counter wrap.
- Mid-burst events:
  - req[1] dropped after 1 pulse of a len-3 burst -> all 3 pulses still issued.
  - rst_n=0 for 5 cycles during the 2nd pulse interval -> outputs 0 from the next edge, no done. After release, requester 0 is granted first.
- Bus change during RUN: change interval and req_len mid-burst -> the current burst is unaffected; the next burst uses the new values.
